riscv32ima_issue_ctrl: RTL and testbench

Issue controller between the instruction decoder and `riscv32ima_alu`. It holds one decoded instruction in an issue slot and tracks in-flight register writes in a 32-entry scoreboard. It withholds issue on read-after-write, write-after-write and fence hazards, and blocks issue behind control-transfer instructions until the branch resolves. It sequences the ALU so that no wrong-path instruction is ever issued after a redirect.

---
 rtl/riscv32ima_pkg.sv | 47 ++++
 rtl/riscv32ima_scoreboard.sv | 35 +++
 rtl/riscv32ima_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_riscv32ima_issue_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv32ima_pkg.sv
// Shared RV32IMA definitions: major opcodes, issue FSM states and the
// opcode class functions used to detect issue hazards.
package riscv32ima_pkg;

  localparam int unsigned OPCODE_WIDTH = 7;

  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD     = 7'h03;
  localparam logic [OPCODE_WIDTH-1:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP_IMM   = 7'h13;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AUIPC    = 7'h17;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE    = 7'h23;
  localparam logic [OPCODE_WIDTH-1:0] OPC_AMO      = 7'h2F;
  localparam logic [OPCODE_WIDTH-1:0] OPC_OP       = 7'h33;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LUI      = 7'h37;
  localparam logic [OPCODE_WIDTH-1:0] OPC_BRANCH   = 7'h63;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JALR     = 7'h67;
  localparam logic [OPCODE_WIDTH-1:0] OPC_JAL      = 7'h6F;
  localparam logic [OPCODE_WIDTH-1:0] OPC_SYSTEM   = 7'h73;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_BR_WAIT = 2'd2
  } state_t;

  function automatic logic writes_rd(input logic [OPCODE_WIDTH-1:0] opc);
    return opc inside {OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_LUI,
                       OPC_OP, OPC_AMO, OPC_JAL, OPC_JALR};
  endfunction

  function automatic logic uses_rs1(input logic [OPCODE_WIDTH-1:0] opc);
    return !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [OPCODE_WIDTH-1:0] opc);
    return opc inside {OPC_BRANCH, OPC_STORE, OPC_OP, OPC_AMO};
  endfunction

  function automatic logic is_ctrl(input logic [OPCODE_WIDTH-1:0] opc);
    return opc inside {OPC_BRANCH, OPC_JAL, OPC_JALR};
  endfunction

  function automatic logic is_serial(input logic [OPCODE_WIDTH-1:0] opc);
    return opc inside {OPC_MISC_MEM, OPC_SYSTEM};
  endfunction

endpackage

// File: rtl/riscv32ima_scoreboard.sv
// Register busy scoreboard: one bit per architectural register.
// Ports: clk, nrst (sync, active-low), set_en/set_addr (issue of a rd
// writer), clr_en/clr_addr (writeback), busy_map (registered bits, x0 = 0).
module riscv32ima_scoreboard
  import riscv32ima_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic                               set_en,
  input  logic [REG_ADDR_WIDTH-1:0]          set_addr,
  input  logic                               clr_en,
  input  logic [REG_ADDR_WIDTH-1:0]          clr_addr,
  output logic [(1<<REG_ADDR_WIDTH)-1:0]     busy_map
);

  logic [(1<<REG_ADDR_WIDTH)-1:0] busy_q, busy_d;

  // Clear first so a same-cycle set of the same register wins; x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_addr != '0)) busy_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_map = busy_q;

endmodule

// File: rtl/riscv32ima_issue_ctrl.sv
// Issue controller between decoder and ALU: single-entry issue slot,
// RAW/WAW/serialization hazard check against the scoreboard, and a
// branch-wait state so nothing issues down a wrong path.
// Ports: dec_* (decoder handshake + fields), iss_* (ALU handshake + slot
// contents), flush/br_done (redirect and branch resolution), wback_reg_*
// (writeback retire), busy_map (scoreboard), stall_cnt (hazard cycles).
module riscv32ima_issue_ctrl
  import riscv32ima_pkg::*;
#(
  parameter int unsigned PAYLOAD_WIDTH  = 160,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            dec_valid,
  output logic                            dec_ready,
  input  logic [OPCODE_WIDTH-1:0]         dec_opcode,
  input  logic [REG_ADDR_WIDTH-1:0]       dec_src0_addr,
  input  logic [REG_ADDR_WIDTH-1:0]       dec_src1_addr,
  input  logic [REG_ADDR_WIDTH-1:0]       dec_dst_addr,
  input  logic [PAYLOAD_WIDTH-1:0]        dec_payload,
  output logic                            iss_valid,
  input  logic                            iss_ready,
  output logic [OPCODE_WIDTH-1:0]         iss_opcode,
  output logic [REG_ADDR_WIDTH-1:0]       iss_src0_addr,
  output logic [REG_ADDR_WIDTH-1:0]       iss_src1_addr,
  output logic [REG_ADDR_WIDTH-1:0]       iss_dst_addr,
  output logic [PAYLOAD_WIDTH-1:0]        iss_payload,
  input  logic                            flush,
  input  logic                            br_done,
  input  logic                            wback_reg_wen,
  input  logic [REG_ADDR_WIDTH-1:0]       wback_reg_addr,
  output logic [(1<<REG_ADDR_WIDTH)-1:0]  busy_map,
  output logic [CNT_WIDTH-1:0]            stall_cnt
);

  state_t state_q, state_d;

  logic [OPCODE_WIDTH-1:0]   slot_opcode_q,  slot_opcode_d;
  logic [REG_ADDR_WIDTH-1:0] slot_src0_q,    slot_src0_d;
  logic [REG_ADDR_WIDTH-1:0] slot_src1_q,    slot_src1_d;
  logic [REG_ADDR_WIDTH-1:0] slot_dst_q,     slot_dst_d;
  logic [PAYLOAD_WIDTH-1:0]  slot_payload_q, slot_payload_d;
  logic [CNT_WIDTH-1:0]      stall_cnt_q,    stall_cnt_d;

  logic hazard;
  logic fire;
  logic accept;

  // Hazard on the slot contents against the registered scoreboard (no bypass).
  always_comb begin
    hazard = 1'b0;
    if (uses_rs1(slot_opcode_q) && busy_map[slot_src0_q]) hazard = 1'b1;
    if (uses_rs2(slot_opcode_q) && busy_map[slot_src1_q]) hazard = 1'b1;
    if (writes_rd(slot_opcode_q) && busy_map[slot_dst_q]) hazard = 1'b1;
    if (is_serial(slot_opcode_q) && (busy_map != '0))     hazard = 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Handshake outputs; flush masks both sides so nothing moves on a redirect.
  always_comb begin
    iss_valid = 1'b0;
    dec_ready = 1'b0;
    unique case (state_q)
      ST_IDLE: dec_ready = !flush;
      ST_HOLD: begin
        iss_valid = !hazard && !flush;
        dec_ready = iss_valid && iss_ready && !is_ctrl(slot_opcode_q);
      end
      default: ;
    endcase
  end

  assign fire   = iss_valid && iss_ready;
  assign accept = dec_valid && dec_ready;

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_HOLD;
      ST_HOLD: begin
        if (flush)                      state_d = ST_IDLE;
        else if (fire) begin
          if (is_ctrl(slot_opcode_q))   state_d = ST_BR_WAIT;
          else if (accept)              state_d = ST_HOLD;
          else                          state_d = ST_IDLE;
        end
      end
      ST_BR_WAIT: if (flush || br_done) state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Slot load; contents are only meaningful while in HOLD.
  always_comb begin
    slot_opcode_d  = slot_opcode_q;
    slot_src0_d    = slot_src0_q;
    slot_src1_d    = slot_src1_q;
    slot_dst_d     = slot_dst_q;
    slot_payload_d = slot_payload_q;
    if (accept) begin
      slot_opcode_d  = dec_opcode;
      slot_src0_d    = dec_src0_addr;
      slot_src1_d    = dec_src1_addr;
      slot_dst_d     = dec_dst_addr;
      slot_payload_d = dec_payload;
    end
  end

  // Saturating count of cycles a held instruction is blocked by a hazard.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_HOLD) && hazard && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      slot_opcode_q  <= '0;
      slot_src0_q    <= '0;
      slot_src1_q    <= '0;
      slot_dst_q     <= '0;
      slot_payload_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      slot_opcode_q  <= slot_opcode_d;
      slot_src0_q    <= slot_src0_d;
      slot_src1_q    <= slot_src1_d;
      slot_dst_q     <= slot_dst_d;
      slot_payload_q <= slot_payload_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  riscv32ima_scoreboard #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_scoreboard (
    .clk      (clk),
    .nrst     (nrst),
    .set_en   (fire && writes_rd(slot_opcode_q)),
    .set_addr (slot_dst_q),
    .clr_en   (wback_reg_wen),
    .clr_addr (wback_reg_addr),
    .busy_map (busy_map)
  );

  assign iss_opcode    = slot_opcode_q;
  assign iss_src0_addr = slot_src0_q;
  assign iss_src1_addr = slot_src1_q;
  assign iss_dst_addr  = slot_dst_q;
  assign iss_payload   = slot_payload_q;
  assign stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_riscv32ima_issue_ctrl.sv
// Bench for riscv32ima_issue_ctrl: directed cycle table, a reset-in-HOLD
// sequence, then randomized traffic against a reference model.
module tb_riscv32ima_issue_ctrl;

  logic         clk;
  logic         nrst;
  logic         dec_valid;
  logic         dec_ready;
  logic [6:0]   dec_opcode;
  logic [4:0]   dec_src0_addr, dec_src1_addr, dec_dst_addr;
  logic [159:0] dec_payload;
  logic         iss_valid;
  logic         iss_ready;
  logic [6:0]   iss_opcode;
  logic [4:0]   iss_src0_addr, iss_src1_addr, iss_dst_addr;
  logic [159:0] iss_payload;
  logic         flush, br_done, wback_reg_wen;
  logic [4:0]   wback_reg_addr;
  logic [31:0]  busy_map;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  riscv32ima_issue_ctrl dut (
    .clk(clk), .nrst(nrst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_opcode(dec_opcode),
    .dec_src0_addr(dec_src0_addr), .dec_src1_addr(dec_src1_addr),
    .dec_dst_addr(dec_dst_addr), .dec_payload(dec_payload),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_opcode(iss_opcode),
    .iss_src0_addr(iss_src0_addr), .iss_src1_addr(iss_src1_addr),
    .iss_dst_addr(iss_dst_addr), .iss_payload(iss_payload),
    .flush(flush), .br_done(br_done),
    .wback_reg_wen(wback_reg_wen), .wback_reg_addr(wback_reg_addr),
    .busy_map(busy_map), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  localparam int OP = 'h33, BR = 'h63, JAL = 'h6F, LUI = 'h37, MM = 'h0F;

  typedef struct {
    logic dv; logic [6:0] op; logic [4:0] s0, s1, d;
    logic ir, fl, bd, wen; logic [4:0] wa;
    logic edr, eiv; logic [31:0] ebusy; logic [15:0] est;
  } vec_t;

  function automatic vec_t mk(input int dv, input int op, input int s0, input int s1, input int d,
                              input int ir, input int fl, input int bd, input int wen, input int wa,
                              input int edr, input int eiv, input int ebusy, input int est);
    vec_t v;
    v.dv = 1'(dv); v.op = 7'(op); v.s0 = 5'(s0); v.s1 = 5'(s1); v.d = 5'(d);
    v.ir = 1'(ir); v.fl = 1'(fl); v.bd = 1'(bd); v.wen = 1'(wen); v.wa = 5'(wa);
    v.edr = 1'(edr); v.eiv = 1'(eiv); v.ebusy = 32'(ebusy); v.est = 16'(est);
    return v;
  endfunction

  // Opcode classes as a lookup: {writes rd, uses rs1, uses rs2, control, serializing}.
  typedef struct packed { logic w; logic r1; logic r2; logic ctl; logic ser; } cls_t;
  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'h03:   return 5'b11000;
      7'h0F:   return 5'b01001;
      7'h13:   return 5'b11000;
      7'h17:   return 5'b10000;
      7'h23:   return 5'b01100;
      7'h2F:   return 5'b11100;
      7'h33:   return 5'b11100;
      7'h37:   return 5'b10000;
      7'h63:   return 5'b01110;
      7'h67:   return 5'b11010;
      7'h6F:   return 5'b10010;
      7'h73:   return 5'b01001;
      default: return 5'b01000;
    endcase
  endfunction

  task automatic drive(input logic dv, input logic [6:0] op, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] d, input logic ir, input logic fl, input logic bd,
                       input logic wen, input logic [4:0] wa);
    dec_valid = dv; dec_opcode = op; dec_src0_addr = s0; dec_src1_addr = s1; dec_dst_addr = d;
    iss_ready = ir; flush = fl; br_done = bd; wback_reg_wen = wen; wback_reg_addr = wa;
  endtask

  vec_t tbl[$];

  // Reference model state.
  bit           m_full, m_wait;
  logic [6:0]   m_op;
  logic [4:0]   m_s0, m_s1, m_d;
  logic [159:0] m_pl;
  bit   [31:0]  m_busy;
  int           m_stall;
  cls_t         c;
  bit           haz, e_iv, e_dr, m_fire, take;
  logic [6:0]   ops[13];

  initial begin
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h2F, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B};

    // Independent stream
    tbl.push_back(mk(1, OP, 2, 3, 1,  1, 0, 0, 0, 0,  1, 0, 'h00, 0));
    tbl.push_back(mk(1, OP, 5, 6, 4,  1, 0, 0, 0, 0,  1, 1, 'h00, 0));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 'h02, 0));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 1,  1, 0, 'h12, 0));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 4,  1, 0, 'h10, 0));
    // RAW hazard on x5, released the cycle after writeback
    tbl.push_back(mk(1, OP, 1, 2, 5,  1, 0, 0, 0, 0,  1, 0, 'h00, 0));
    tbl.push_back(mk(1, OP, 5, 0, 6,  1, 0, 0, 0, 0,  1, 1, 'h00, 0));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 'h20, 0));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 5,  0, 0, 'h20, 1));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 6,  1, 0, 'h40, 2));
    // Branch resolved by br_done
    tbl.push_back(mk(1, BR, 1, 2, 0,  1, 0, 0, 0, 0,  1, 0, 'h00, 2));
    tbl.push_back(mk(1, OP, 1, 2, 7,  1, 0, 0, 0, 0,  0, 1, 'h00, 2));
    tbl.push_back(mk(1, OP, 1, 2, 7,  1, 0, 0, 0, 0,  0, 0, 'h00, 2));
    tbl.push_back(mk(1, OP, 1, 2, 7,  1, 0, 1, 0, 0,  0, 0, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0, 'h00, 2));
    // JAL with backpressure, resolved by flush; offer during flush is refused
    tbl.push_back(mk(1, JAL, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  0, 0, 0, 0, 0,  0, 1, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  0, 1, 'h00, 2));
    tbl.push_back(mk(1, OP, 0, 0, 3,  1, 1, 0, 0, 0,  0, 0, 'h02, 2));
    tbl.push_back(mk(1, OP, 0, 0, 3,  1, 1, 0, 0, 0,  0, 0, 'h02, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 1,  1, 0, 'h02, 2));
    // Write to x0
    tbl.push_back(mk(1, LUI, 0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0, 'h00, 2));
    // Set/clear collision on x7
    tbl.push_back(mk(1, OP, 1, 2, 7,  1, 0, 0, 0, 0,  1, 0, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 7,  1, 1, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 7,  1, 0, 'h80, 2));
    // Serializing MISC_MEM behind x3
    tbl.push_back(mk(1, OP, 1, 2, 3,  1, 0, 0, 0, 0,  1, 0, 'h00, 2));
    tbl.push_back(mk(1, MM, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 'h00, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  0, 0, 'h08, 2));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 1, 3,  0, 0, 'h08, 3));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 1, 'h00, 4));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0, 'h00, 4));
    // Flush masks a would-be fire in HOLD
    tbl.push_back(mk(1, OP, 2, 3, 1,  1, 0, 0, 0, 0,  1, 0, 'h00, 4));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 1, 0, 0, 0,  0, 0, 'h00, 4));
    tbl.push_back(mk(0, OP, 0, 0, 0,  1, 0, 0, 0, 0,  1, 0, 'h00, 4));

    dec_payload = 160'h0;
    nrst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("reset_dec_ready", 160'(dec_ready), 160'(1));
    chk("reset_iss_valid", 160'(iss_valid), 160'(0));
    chk("reset_busy_map",  160'(busy_map),  160'(0));
    chk("reset_stall_cnt", 160'(stall_cnt), 160'(0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].dv, tbl[i].op, tbl[i].s0, tbl[i].s1, tbl[i].d,
            tbl[i].ir, tbl[i].fl, tbl[i].bd, tbl[i].wen, tbl[i].wa);
      #1;
      chk($sformatf("vec%0d_dec_ready", i), 160'(dec_ready), 160'(tbl[i].edr));
      chk($sformatf("vec%0d_iss_valid", i), 160'(iss_valid), 160'(tbl[i].eiv));
      chk($sformatf("vec%0d_busy_map",  i), 160'(busy_map),  160'(tbl[i].ebusy));
      chk($sformatf("vec%0d_stall_cnt", i), 160'(stall_cnt), 160'(tbl[i].est));
    end

    // Reset while an instruction is held behind a busy register.
    @(negedge clk); drive(1, 7'h33, 5'd2, 5'd3, 5'd1, 1, 0, 0, 0, 5'd0);
    @(negedge clk); drive(1, 7'h33, 5'd1, 5'd0, 5'd2, 1, 0, 0, 0, 5'd0);
    @(negedge clk); drive(0, 7'h00, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 5'd0);
    #1;
    chk("rst_hold_pre_iss_valid", 160'(iss_valid), 160'(0));
    chk("rst_hold_pre_busy_map",  160'(busy_map),  160'(32'h2));
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("rst_hold_iss_valid", 160'(iss_valid), 160'(0));
    chk("rst_hold_busy_map",  160'(busy_map),  160'(0));
    chk("rst_hold_stall_cnt", 160'(stall_cnt), 160'(0));
    chk("rst_hold_dec_ready", 160'(dec_ready), 160'(1));

    // Randomized traffic against the reference model.
    m_full = 0; m_wait = 0; m_busy = '0; m_stall = 0;
    m_op = '0; m_s0 = '0; m_s1 = '0; m_d = '0; m_pl = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      dec_valid      = ($urandom_range(0, 3) != 0);
      dec_opcode     = ops[$urandom_range(0, 12)];
      dec_src0_addr  = 5'($urandom_range(0, 7));
      dec_src1_addr  = 5'($urandom_range(0, 7));
      dec_dst_addr   = 5'($urandom_range(0, 7));
      dec_payload    = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      iss_ready      = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      br_done        = ($urandom_range(0, 3) == 0);
      wback_reg_wen  = ($urandom_range(0, 1) == 0);
      wback_reg_addr = 5'($urandom_range(0, 7));
      #1;

      c      = classify(m_op);
      haz    = m_full && ((c.r1 && m_busy[m_s0]) || (c.r2 && m_busy[m_s1]) ||
                          (c.w && m_busy[m_d]) || (c.ser && (m_busy != 0)));
      e_iv   = m_full && !haz && !flush;
      m_fire = e_iv && iss_ready;
      e_dr   = (!m_full && !m_wait) ? !flush : (m_fire && !c.ctl);

      chk("rnd_dec_ready", 160'(dec_ready), 160'(e_dr));
      chk("rnd_iss_valid", 160'(iss_valid), 160'(e_iv));
      chk("rnd_busy_map",  160'(busy_map),  160'(m_busy));
      chk("rnd_stall_cnt", 160'(stall_cnt), 160'(m_stall));
      if (e_iv) begin
        chk("rnd_iss_opcode",  160'(iss_opcode),    160'(m_op));
        chk("rnd_iss_src0",    160'(iss_src0_addr), 160'(m_s0));
        chk("rnd_iss_src1",    160'(iss_src1_addr), 160'(m_s1));
        chk("rnd_iss_dst",     160'(iss_dst_addr),  160'(m_d));
        chk("rnd_iss_payload", iss_payload,         m_pl);
      end

      take = dec_valid && e_dr;
      if (haz && m_stall < 65535) m_stall++;
      if (wback_reg_wen && wback_reg_addr != 0) m_busy[wback_reg_addr] = 1'b0;
      if (m_fire && c.w && m_d != 0) m_busy[m_d] = 1'b1;
      if (flush) begin
        m_full = 0; m_wait = 0;
      end else if (m_wait) begin
        if (br_done) m_wait = 0;
      end else if (m_full) begin
        if (m_fire) begin
          if (c.ctl) begin m_full = 0; m_wait = 1; end
          else if (!take) m_full = 0;
        end
      end else if (take) begin
        m_full = 1;
      end
      if (take) begin
        m_op = dec_opcode; m_s0 = dec_src0_addr; m_s1 = dec_src1_addr;
        m_d = dec_dst_addr; m_pl = dec_payload;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
